// File: rtl/pipe_pkg.sv
// Control-field layout shared by the ID/EX stage register and its hazard logic.
// Pure declarations: no latency, no flow control.
package pipe_pkg;

    localparam int CTRL_W        = 7;
    // Bit positions within {ALUOp[1:0],ALUSrc,RegWrite,MemtoReg,MemRead,MemWrite}
    localparam int CTRL_ALUOP    = 5;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_REGWRITE = 3;
    localparam int CTRL_MEMTOREG = 2;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMWRITE = 0;

    localparam logic [CTRL_W-1:0] CTRL_NOP = 7'b0;
    localparam logic [4:0]        REG_X0   = 5'd0;

    function automatic logic isMemRead(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEMREAD];
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ID-side decoded instruction bundle and its registered EX-side copy.
// master = ID stage (drives ID_*, observes EX_*); slave = ID/EX register.
interface id_ex_stage_reg_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    import pipe_pkg::*;

    logic                  ID_valid_i;
    logic [DATA_W-1:0]     ID_PC_i;
    logic [DATA_W-1:0]     ID_RS1data_i;
    logic [DATA_W-1:0]     ID_RS2data_i;
    logic [DATA_W-1:0]     ID_Imm_i;
    logic [REG_ADDR_W-1:0] ID_rs1_i;
    logic [REG_ADDR_W-1:0] ID_rs2_i;
    logic [REG_ADDR_W-1:0] ID_Rd_i;
    logic [9:0]            ID_funct_i;
    logic [CTRL_W-1:0]     ID_ctrl_i;

    logic                  EX_valid_o;
    logic [DATA_W-1:0]     EX_PC_o;
    logic [DATA_W-1:0]     EX_RS1data_o;
    logic [DATA_W-1:0]     EX_RS2data_o;
    logic [DATA_W-1:0]     EX_Imm_o;
    logic [REG_ADDR_W-1:0] EX_rs1_o;
    logic [REG_ADDR_W-1:0] EX_rs2_o;
    logic [REG_ADDR_W-1:0] EX_Rd_o;
    logic [9:0]            EX_funct_o;
    logic [CTRL_W-1:0]     EX_ctrl_o;

    modport master (
        output ID_valid_i, ID_PC_i, ID_RS1data_i, ID_RS2data_i, ID_Imm_i,
               ID_rs1_i, ID_rs2_i, ID_Rd_i, ID_funct_i, ID_ctrl_i,
        input  EX_valid_o, EX_PC_o, EX_RS1data_o, EX_RS2data_o, EX_Imm_o,
               EX_rs1_o, EX_rs2_o, EX_Rd_o, EX_funct_o, EX_ctrl_o
    );

    modport slave (
        input  ID_valid_i, ID_PC_i, ID_RS1data_i, ID_RS2data_i, ID_Imm_i,
               ID_rs1_i, ID_rs2_i, ID_Rd_i, ID_funct_i, ID_ctrl_i,
        output EX_valid_o, EX_PC_o, EX_RS1data_o, EX_RS2data_o, EX_Imm_o,
               EX_rs1_o, EX_rs2_o, EX_Rd_o, EX_funct_o, EX_ctrl_o
    );

endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags an ID instruction reading the Rd of a load sitting in EX.
// Zero latency (combinational); drops PC/IF-ID write enables on hazard or external stall.
module load_use_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  idValid,
    input  logic [REG_ADDR_W-1:0] idRs1,
    input  logic [REG_ADDR_W-1:0] idRs2,
    input  logic                  exValid,
    input  logic                  exMemRead,
    input  logic [REG_ADDR_W-1:0] exRd,
    input  logic                  extStall,
    output logic                  hz,
    output logic                  PCWrite_o,
    output logic                  IFIDWrite_o
);

    logic rdMatch;

    // x0 is hardwired zero, so a load targeting it never produces a dependency
    assign rdMatch = (exRd != REG_ADDR_W'(0)) && ((exRd == idRs1) || (exRd == idRs2));
    assign hz      = idValid && exValid && exMemRead && rdMatch;

    assign PCWrite_o   = ~(hz | extStall);
    assign IFIDWrite_o = ~(hz | extStall);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion; 1-cycle ID->EX, holds on Ext_stall_i, kills on Flush_i.
// Optional bubble/flush perf counters under `BUBBLE_COUNT_EN (tied to zero otherwise).
module id_ex_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    id_ex_stage_reg_if.slave    pipe,
    input  logic                Flush_i,
    input  logic                Ext_stall_i,
    output logic                PCWrite_o,
    output logic                IFIDWrite_o,
    output logic [CNT_W-1:0]    Stall_cnt_o,
    output logic [CNT_W-1:0]    Flush_cnt_o
);

    logic                  exValid;
    logic [DATA_W-1:0]     exPC;
    logic [DATA_W-1:0]     exRS1data;
    logic [DATA_W-1:0]     exRS2data;
    logic [DATA_W-1:0]     exImm;
    logic [REG_ADDR_W-1:0] exRs1;
    logic [REG_ADDR_W-1:0] exRs2;
    logic [REG_ADDR_W-1:0] exRd;
    logic [9:0]            exFunct;
    logic [CTRL_W-1:0]     exCtrl;
    logic                  hz;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .idValid     (pipe.ID_valid_i),
        .idRs1       (pipe.ID_rs1_i),
        .idRs2       (pipe.ID_rs2_i),
        .exValid     (exValid),
        .exMemRead   (isMemRead(exCtrl)),
        .exRd        (exRd),
        .extStall    (Ext_stall_i),
        .hz          (hz),
        .PCWrite_o   (PCWrite_o),
        .IFIDWrite_o (IFIDWrite_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            exValid   <= 1'b0;
            exPC      <= '0;
            exRS1data <= '0;
            exRS2data <= '0;
            exImm     <= '0;
            exRs1     <= '0;
            exRs2     <= '0;
            exRd      <= '0;
            exFunct   <= '0;
            exCtrl    <= CTRL_NOP;
        end else if (!Ext_stall_i) begin
            // Data fields load unconditionally; only valid/ctrl/Rd decide whether EX sees a bubble
            exPC      <= pipe.ID_PC_i;
            exRS1data <= pipe.ID_RS1data_i;
            exRS2data <= pipe.ID_RS2data_i;
            exImm     <= pipe.ID_Imm_i;
            exRs1     <= pipe.ID_rs1_i;
            exRs2     <= pipe.ID_rs2_i;
            exFunct   <= pipe.ID_funct_i;
            if (Flush_i || hz) begin
                exValid <= 1'b0;
                exCtrl  <= CTRL_NOP;
                exRd    <= '0;
            end else begin
                exValid <= pipe.ID_valid_i;
                exCtrl  <= pipe.ID_valid_i ? pipe.ID_ctrl_i : CTRL_NOP;
                exRd    <= pipe.ID_Rd_i;
            end
        end
    end

`ifdef BUBBLE_COUNT_EN
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;

    // Flush takes precedence, so a same-cycle hazard is counted only as a flush
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else if (!Ext_stall_i) begin
            if (Flush_i)
                flushCnt <= flushCnt + CNT_W'(1);
            else if (hz)
                stallCnt <= stallCnt + CNT_W'(1);
        end
    end

    assign Stall_cnt_o = stallCnt;
    assign Flush_cnt_o = flushCnt;
`else
    assign Stall_cnt_o = '0;
    assign Flush_cnt_o = '0;
`endif

    assign pipe.EX_valid_o   = exValid;
    assign pipe.EX_PC_o      = exPC;
    assign pipe.EX_RS1data_o = exRS1data;
    assign pipe.EX_RS2data_o = exRS2data;
    assign pipe.EX_Imm_o     = exImm;
    assign pipe.EX_rs1_o     = exRs1;
    assign pipe.EX_rs2_o     = exRs2;
    assign pipe.EX_Rd_o      = exRd;
    assign pipe.EX_funct_o   = exFunct;
    assign pipe.EX_ctrl_o    = exCtrl;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: load-use bubble, x0 load, flush vs hazard, external stall, reset, ALU streaming.
module tb_id_ex_stage_reg;

    localparam logic [6:0] CTRL_ALU = 7'b1001000;  // ALUOp=10, RegWrite
    localparam logic [6:0] CTRL_LW  = 7'b0011110;  // ALUSrc, RegWrite, MemtoReg, MemRead

`ifdef BUBBLE_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        Flush_i;
    logic        Ext_stall_i;
    logic        PCWrite_o;
    logic        IFIDWrite_o;
    logic [31:0] Stall_cnt_o;
    logic [31:0] Flush_cnt_o;

    int nChecks = 0;
    int nPass   = 0;
    int expStall = 0;
    int expFlush = 0;

    id_ex_stage_reg_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

    id_ex_stage_reg #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(32)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .pipe        (bus.slave),
        .Flush_i     (Flush_i),
        .Ext_stall_i (Ext_stall_i),
        .PCWrite_o   (PCWrite_o),
        .IFIDWrite_o (IFIDWrite_o),
        .Stall_cnt_o (Stall_cnt_o),
        .Flush_cnt_o (Flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic checkCnt(input string tag);
        check({tag, "_stallcnt"}, 64'(Stall_cnt_o), CNT_ON ? 64'(expStall) : 64'd0);
        check({tag, "_flushcnt"}, 64'(Flush_cnt_o), CNT_ON ? 64'(expFlush) : 64'd0);
    endtask

    task automatic driveId(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd, input logic [6:0] ctrl);
        bus.ID_valid_i   = v;
        bus.ID_PC_i      = pc;
        bus.ID_RS1data_i = 32'h1000_0000 | pc;
        bus.ID_RS2data_i = 32'h2000_0000 | pc;
        bus.ID_Imm_i     = 32'hFFFF_FFF0;
        bus.ID_rs1_i     = rs1;
        bus.ID_rs2_i     = rs2;
        bus.ID_Rd_i      = rd;
        bus.ID_funct_i   = 10'h0A5;
        bus.ID_ctrl_i    = ctrl;
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        Flush_i = 1'b0;
        Ext_stall_i = 1'b0;
        driveId(1'b1, 32'h40, 5'd1, 5'd2, 5'd3, CTRL_ALU);
        step();
        step();
        check("rst_valid", 64'(bus.EX_valid_o), 64'd0);
        check("rst_ctrl",  64'(bus.EX_ctrl_o),  64'd0);
        check("rst_rd",    64'(bus.EX_Rd_o),    64'd0);
        check("rst_pcw",   64'(PCWrite_o),      64'd1);
        checkCnt("rst");
        rst_i = 1'b0;

        // Back-to-back independent ALU ops
        driveId(1'b1, 32'h100, 5'd1, 5'd2, 5'd10, CTRL_ALU);
        #1 check("alu1_pcw", 64'(PCWrite_o), 64'd1);
        step();
        check("alu1_rd",    64'(bus.EX_Rd_o),    64'd10);
        check("alu1_valid", 64'(bus.EX_valid_o), 64'd1);
        check("alu1_ctrl",  64'(bus.EX_ctrl_o),  64'(CTRL_ALU));
        check("alu1_pc",    64'(bus.EX_PC_o),    64'h100);
        driveId(1'b1, 32'h104, 5'd10, 5'd3, 5'd11, CTRL_ALU);
        #1 check("alu2_ifidw", 64'(IFIDWrite_o), 64'd1);
        step();
        check("alu2_rd",   64'(bus.EX_Rd_o),   64'd11);
        check("alu2_rs1",  64'(bus.EX_rs1_o),  64'd10);
        check("alu2_rs1d", 64'(bus.EX_RS1data_o), 64'h1000_0104);
        checkCnt("alu2");

        // Load-use: lw x5 then add x6,x5,x7
        driveId(1'b1, 32'h108, 5'd1, 5'd0, 5'd5, CTRL_LW);
        step();
        check("lw_ctrl", 64'(bus.EX_ctrl_o), 64'(CTRL_LW));
        driveId(1'b1, 32'h10C, 5'd5, 5'd7, 5'd6, CTRL_ALU);
        #1;
        check("lu_pcw",   64'(PCWrite_o),   64'd0);
        check("lu_ifidw", 64'(IFIDWrite_o), 64'd0);
        step();
        expStall++;
        check("lu_bub_valid", 64'(bus.EX_valid_o), 64'd0);
        check("lu_bub_ctrl",  64'(bus.EX_ctrl_o),  64'd0);
        check("lu_bub_rd",    64'(bus.EX_Rd_o),    64'd0);
        check("lu_bub_pcw",   64'(PCWrite_o),      64'd1);
        checkCnt("lu_bub");
        step();
        check("lu_add_rd",    64'(bus.EX_Rd_o),    64'd6);
        check("lu_add_valid", 64'(bus.EX_valid_o), 64'd1);
        check("lu_add_pc",    64'(bus.EX_PC_o),    64'h10C);

        // lw x0 followed by a reader of x0: no stall
        driveId(1'b1, 32'h110, 5'd1, 5'd0, 5'd0, CTRL_LW);
        step();
        driveId(1'b1, 32'h114, 5'd0, 5'd0, 5'd6, CTRL_ALU);
        #1 check("x0_pcw", 64'(PCWrite_o), 64'd1);
        step();
        check("x0_add_rd",    64'(bus.EX_Rd_o),    64'd6);
        check("x0_add_valid", 64'(bus.EX_valid_o), 64'd1);
        checkCnt("x0");

        // External stall holds EX=lw x5 for 3 cycles
        driveId(1'b1, 32'h118, 5'd2, 5'd0, 5'd5, CTRL_LW);
        step();
        driveId(1'b1, 32'h11C, 5'd5, 5'd7, 5'd6, CTRL_ALU);
        Ext_stall_i = 1'b1;
        #1 check("es_pcw", 64'(PCWrite_o), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("es_rd",   64'(bus.EX_Rd_o),   64'd5);
            check("es_ctrl", 64'(bus.EX_ctrl_o), 64'(CTRL_LW));
            check("es_pc",   64'(bus.EX_PC_o),   64'h118);
            checkCnt("es");
        end
        Ext_stall_i = 1'b0;

        // Flush with a live hazard: flush wins and is the only count
        Flush_i = 1'b1;
        #1 check("fl_hz_pcw", 64'(PCWrite_o), 64'd0);
        step();
        expFlush++;
        Flush_i = 1'b0;
        check("fl_valid", 64'(bus.EX_valid_o), 64'd0);
        check("fl_ctrl",  64'(bus.EX_ctrl_o),  64'd0);
        check("fl_rd",    64'(bus.EX_Rd_o),    64'd0);
        checkCnt("fl");
        step();
        check("fl_next_rd", 64'(bus.EX_Rd_o), 64'd6);

        // Invalid ID slot forces ctrl to zero while still loading Rd
        driveId(1'b0, 32'h120, 5'd1, 5'd2, 5'd9, CTRL_ALU);
        step();
        check("inv_valid", 64'(bus.EX_valid_o), 64'd0);
        check("inv_ctrl",  64'(bus.EX_ctrl_o),  64'd0);
        check("inv_rd",    64'(bus.EX_Rd_o),    64'd9);

        // Reset arriving while a load-use bubble is pending
        driveId(1'b1, 32'h124, 5'd3, 5'd0, 5'd5, CTRL_LW);
        step();
        driveId(1'b1, 32'h128, 5'd5, 5'd7, 5'd6, CTRL_ALU);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        expStall = 0;
        expFlush = 0;
        check("mr_valid", 64'(bus.EX_valid_o), 64'd0);
        check("mr_ctrl",  64'(bus.EX_ctrl_o),  64'd0);
        check("mr_rd",    64'(bus.EX_Rd_o),    64'd0);
        check("mr_pc",    64'(bus.EX_PC_o),    64'd0);
        check("mr_pcw",   64'(PCWrite_o),      64'd1);
        checkCnt("mr");

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
